// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bundle shared by alu_seq and its multiplier
package alu_seq_pkg;
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_LOADI = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_SAR   = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: WIDTH-step shift-add multiplier
// Ports: clk, res (async active-low), start loads a/b, done is high for one cycle
// once prod holds the full 2*WIDTH-bit product.
module alu_mul_iter #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic               run_q, run_d;
    assign done = run_q && cnt_q == (SHW+1)'(WIDTH);
    assign prod = acc_q;
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (done) begin
            run_d = 1'b0;
        end else if (run_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready issue, flags and optional iterative multiplier
// Ports: clk, res (async active-low), in_valid/in_ready issue handshake, OP/Lbus/Rbus
// operation, Obus registered result, out_valid one-cycle result pulse, flag_z/n/c/v.
// Build option ALU_MUL_EN: adds the multiplier and BUSY state; otherwise OP 0xA is a NOP.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] Lbus,
    input  logic [WIDTH-1:0] Rbus,
    output logic [WIDTH-1:0] Obus,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    logic [WIDTH-1:0] obus_q, obus_d, alu_r;
    flags_t           flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   sum, shl_w, shr_w, sar_w;
    logic [SHW-1:0]   amt;
    logic             accept, upd, alu_c, alu_v;
`ifdef ALU_MUL_EN
    state_e             state_q, state_d;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    assign in_ready = state_q == ST_IDLE;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .res(res), .start(mul_start), .a(Lbus), .b(Rbus),
        .done(mul_done), .prod(mul_prod)
    );
`else
    assign in_ready = 1'b1;
`endif
    assign accept = in_valid && in_ready;
    always_comb begin
        amt   = Rbus[SHW-1:0];
        sum   = {1'b0, Lbus} + {1'b0, (OP == OP_SUB) ? ~Rbus : Rbus} + {{WIDTH{1'b0}}, OP == OP_SUB};
        // Shifts run one bit wider so the last bit shifted out lands in the extra bit; amount 0 leaves it 0.
        shl_w = {1'b0, Lbus} << amt;
        shr_w = {Lbus, 1'b0} >> amt;
        sar_w = $signed({Lbus, 1'b0}) >>> amt;
        alu_r = (OP == OP_ADD || OP == OP_SUB) ? sum[WIDTH-1:0] :
                OP == OP_AND   ? Lbus & Rbus :
                OP == OP_OR    ? Lbus | Rbus :
                OP == OP_XOR   ? Lbus ^ Rbus :
                OP == OP_LOADI ? Rbus :
                OP == OP_SHL   ? shl_w[WIDTH-1:0] :
                OP == OP_SHR   ? shr_w[WIDTH:1] : sar_w[WIDTH:1];
        alu_c = (OP == OP_ADD || OP == OP_SUB) ? sum[WIDTH] :
                OP == OP_SHL ? shl_w[WIDTH] :
                OP == OP_SHR ? shr_w[0] :
                OP == OP_SAR ? sar_w[0] : 1'b0;
        alu_v = OP == OP_ADD ? (Lbus[WIDTH-1] == Rbus[WIDTH-1]) && (alu_r[WIDTH-1] != Lbus[WIDTH-1]) :
                OP == OP_SUB ? (Lbus[WIDTH-1] != Rbus[WIDTH-1]) && (alu_r[WIDTH-1] != Lbus[WIDTH-1]) : 1'b0;
        upd         = accept && OP >= OP_ADD && OP <= OP_SAR;
        obus_d      = upd ? alu_r : obus_q;
        flags_d     = upd ? '{z: alu_r == '0, n: alu_r[WIDTH-1], c: alu_c, v: alu_v} : flags_q;
        out_valid_d = upd;
`ifdef ALU_MUL_EN
        mul_start = accept && OP == OP_MUL;
        state_d   = mul_start ? ST_BUSY : mul_done ? ST_IDLE : state_q;
        if (mul_done) begin
            obus_d      = mul_prod[WIDTH-1:0];
            flags_d     = '{z: mul_prod[WIDTH-1:0] == '0, n: mul_prod[WIDTH-1],
                            c: |mul_prod[2*WIDTH-1:WIDTH], v: 1'b0};
            out_valid_d = 1'b1;
        end
`endif
    end
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            obus_q      <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q     <= ST_IDLE;
`endif
        end else begin
            obus_q      <= obus_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            state_q     <= state_d;
`endif
        end
    end
    assign Obus      = obus_q;
    assign out_valid = out_valid_q;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16), flags shown as {z,n,c,v}
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  OP = 4'h0;
    logic [15:0] Lbus = '0;
    logic [15:0] Rbus = '0;
    logic [15:0] Obus;
    logic        out_valid, flag_z, flag_n, flag_c, flag_v;
    logic [3:0]  fl;
    int          errors = 0;
    int          checks = 0;
    assign fl = {flag_z, flag_n, flag_c, flag_v};
    always #5 clk = ~clk;
    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .OP(OP),
        .Lbus(Lbus), .Rbus(Rbus), .Obus(Obus), .out_valid(out_valid),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );
    task automatic issue(input logic [3:0] op, input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        OP = op; Lbus = l; Rbus = r; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    task automatic test_reset;
        #12;
        checks++; if (Obus !== 16'h0000) begin errors++; $display("FAIL reset_obus got %h want 0000", Obus); end
        checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", fl); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk) res = 1'b1;
    endtask
    task automatic test_arith;
        logic [3:0]  op [4] = '{4'h1, 4'h1, 4'h2, 4'h2};
        logic [15:0] l  [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        logic [15:0] r  [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002};
        logic [15:0] eo [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [3:0]  ef [4] = '{4'b1010, 4'b0101, 4'b0011, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            issue(op[i], l[i], r[i]);
            checks++; if (Obus !== eo[i]) begin errors++; $display("FAIL arith%0d_obus got %h want %h", i, Obus, eo[i]); end
            checks++; if (fl !== ef[i]) begin errors++; $display("FAIL arith%0d_flags got %b want %b", i, fl, ef[i]); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_out_valid got %b want 1", i, out_valid); end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", out_valid); end
    endtask
    task automatic test_logic_shift;
        logic [3:0]  op [10] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'h7, 4'h7, 4'h7, 4'h8};
        logic [15:0] l  [10] = '{16'hF0F0, 16'h0F00, 16'h1234, 16'h5555, 16'h8001,
                                 16'h8001, 16'h8001, 16'h1234, 16'h0001, 16'h8000};
        logic [15:0] r  [10] = '{16'hFF00, 16'h00F0, 16'h1234, 16'hBEEF, 16'h0011,
                                 16'h0011, 16'h0011, 16'h0010, 16'h000F, 16'hFFFF};
        logic [15:0] eo [10] = '{16'hF000, 16'h0FF0, 16'h0000, 16'hBEEF, 16'h4000,
                                 16'hC000, 16'h0002, 16'h1234, 16'h8000, 16'h0001};
        logic [3:0]  ef [10] = '{4'b0100, 4'b0000, 4'b1000, 4'b0100, 4'b0010,
                                 4'b0110, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            issue(op[i], l[i], r[i]);
            checks++; if (Obus !== eo[i]) begin errors++; $display("FAIL op%0d_obus got %h want %h", i, Obus, eo[i]); end
            checks++; if (fl !== ef[i]) begin errors++; $display("FAIL op%0d_flags got %b want %b", i, fl, ef[i]); end
        end
        issue(4'h9, 16'h8000, 16'h002F);
        checks++; if (Obus !== 16'hFFFF || fl !== 4'b0100) begin errors++; $display("FAIL sar15 got %h/%b want ffff/0100", Obus, fl); end
    endtask
    task automatic test_back_to_back;
        @(negedge clk);
        OP = 4'h1; Lbus = 16'h0001; Rbus = 16'h0001; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (Obus !== 16'h0002 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b want 0002/1", Obus, out_valid); end
        OP = 4'h5; Lbus = 16'h0003; Rbus = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (Obus !== 16'h0006 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b want 0006/1", Obus, out_valid); end
    endtask
    task automatic test_nop_reserved;
        logic [3:0] op [3] = '{4'h0, 4'hE, 4'hB};
        issue(4'h1, 16'hFFFF, 16'h0006);
        checks++; if (Obus !== 16'h0005 || fl !== 4'b0010) begin errors++; $display("FAIL nop_setup got %h/%b want 0005/0010", Obus, fl); end
        for (int i = 0; i < 3; i++) begin
            issue(op[i], 16'h0000, 16'h0000);
            checks++; if (Obus !== 16'h0005) begin errors++; $display("FAIL hold%0d_obus got %h want 0005", i, Obus); end
            checks++; if (fl !== 4'b0010) begin errors++; $display("FAIL hold%0d_flags got %b want 0010", i, fl); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold%0d_out_valid got %b want 0", i, out_valid); end
        end
    endtask
`ifdef ALU_MUL_EN
    task automatic test_mul;
        int n;
        @(negedge clk);
        OP = 4'hA; Lbus = 16'h0123; Rbus = 16'h0010; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy got %b/%b want 0/0", in_ready, out_valid); end
        OP = 4'h1; Lbus = 16'h0001; Rbus = 16'h0001;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (out_valid === 1'b1) break;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL mul_latency got %0d want 17", n); end
        checks++; if (Obus !== 16'h1230 || fl !== 4'b0000) begin errors++; $display("FAIL mul1_result got %h/%b want 1230/0000", Obus, fl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (Obus !== 16'h0002 || out_valid !== 1'b1) begin errors++; $display("FAIL held_add got %h/%b want 0002/1", Obus, out_valid); end
        issue(4'hA, 16'h1000, 16'h0010);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (out_valid === 1'b1) break;
        end
        checks++; if (n !== 17 || Obus !== 16'h0000 || fl !== 4'b1010) begin errors++; $display("FAIL mul2 got n=%0d %h/%b want 17 0000/1010", n, Obus, fl); end
    endtask
`else
    task automatic test_mul;
        issue(4'h1, 16'h0003, 16'h0004);
        issue(4'hA, 16'h0000, 16'h0000);
        checks++; if (Obus !== 16'h0007 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_as_nop got %h/%b want 0007/0", Obus, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready got %b want 1", in_ready); end
    endtask
`endif
    task automatic test_async_reset;
        int seen = 0;
        issue(4'h1, 16'hFFFF, 16'h0006);
`ifdef ALU_MUL_EN
        issue(4'hA, 16'h0123, 16'h0010);
`endif
        repeat (4) @(posedge clk);
        #3 res = 1'b0;
        #1;
        checks++; if (Obus !== 16'h0000 || fl !== 4'b0000) begin errors++; $display("FAIL areset_state got %h/%b want 0000/0000", Obus, fl); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_hs got %b/%b want 1/0", in_ready, out_valid); end
        @(negedge clk) res = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL areset_no_pulse got %0d pulses want 0", seen); end
    endtask
    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_back_to_back();
        test_nop_reserved();
        test_mul();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
